// File: rtl/ltl_mon_pkg.sv
// Shared types and defaults for the LTL monitor report path.
// Entry layout is {report vector, symbol index}; width helper lets instances size storage.
package ltl_mon_pkg;

  localparam int NUM_REPORTS_DEF = 4;
  localparam int TS_WIDTH_DEF    = 32;

  typedef struct packed {
    logic [NUM_REPORTS_DEF-1:0] report;
    logic [TS_WIDTH_DEF-1:0]    ts;
  } evt_entry_def_t;

  function automatic int entry_width(input int num_reports, input int ts_width);
    return num_reports + ts_width;
  endfunction

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous FIFO, registered storage and count; head visible the cycle after a write.
// A push while full is accepted only when a pop happens in the same cycle.
module ltl_report_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head reads as zero when empty so reset/clear leave the outputs quiet.
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ltl_report_collector.sv
// Time-stamps automaton reports and queues them; evt_valid follows the symbol by 2 cycles.
// When the queue is full and not popped, new events are dropped and counted.
module ltl_report_collector
  import ltl_mon_pkg::*;
#(
  parameter int NUM_REPORTS    = NUM_REPORTS_DEF,
  parameter int TS_WIDTH       = TS_WIDTH_DEF,
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         run,
  input  logic                         clear,
  input  logic                         edge_mode,
  input  logic [NUM_REPORTS-1:0]       report_i,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [NUM_REPORTS-1:0]       evt_report,
  output logic [TS_WIDTH-1:0]          evt_ts,
  output logic [$clog2(DEPTH):0]       fifo_count,
  output logic                         overflow,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count,
  output logic                         first_valid,
  output logic [NUM_REPORTS-1:0]       first_report,
  output logic [TS_WIDTH-1:0]          first_ts,
  output logic [TS_WIDTH-1:0]          symbol_count
);

  localparam int EW = entry_width(NUM_REPORTS, TS_WIDTH);

  typedef struct packed {
    logic [NUM_REPORTS-1:0] report;
    logic [TS_WIDTH-1:0]    ts;
  } entry_t;

  logic                   run_d;
  logic [TS_WIDTH-1:0]    idx_d;
  logic [NUM_REPORTS-1:0] report_prev;
  logic [NUM_REPORTS-1:0] filt;
  logic                   evt_hit;
  logic                   pop;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  entry_t                 push_entry;
  entry_t                 head_entry;

  // Reports lag the consumed symbol by one cycle, so run_d/idx_d qualify and stamp them.
  assign filt       = edge_mode ? (report_i & ~report_prev) : report_i;
  assign evt_hit    = run_d & (|filt);
  assign pop        = evt_valid & evt_ready;
  assign drop       = evt_hit & fifo_full & ~pop;
  assign push_entry = '{report: filt, ts: idx_d};

  assign evt_valid  = ~fifo_empty;
  assign evt_report = head_entry.report;
  assign evt_ts     = head_entry.ts;

  ltl_report_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (clear),
    .push     (evt_hit),
    .push_dat (push_entry),
    .pop      (pop),
    .pop_dat  (head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_d        <= 1'b0;
      idx_d        <= '0;
      report_prev  <= '0;
      symbol_count <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      first_valid  <= 1'b0;
      first_report <= '0;
      first_ts     <= '0;
    end else if (clear) begin
      run_d        <= 1'b0;
      idx_d        <= '0;
      report_prev  <= '0;
      symbol_count <= '0;
      overflow     <= 1'b0;
      drop_count   <= '0;
      first_valid  <= 1'b0;
      first_report <= '0;
      first_ts     <= '0;
    end else begin
      run_d <= run;
      if (run) begin
        idx_d        <= symbol_count;
        symbol_count <= symbol_count + 1'b1;
      end
      if (run_d) report_prev <= report_i;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
      // Captures whether the event was queued or dropped.
      if (evt_hit && !first_valid) begin
        first_valid  <= 1'b1;
        first_report <= filt;
        first_ts     <= idx_d;
      end
    end
  end

endmodule
